// File: rtl/aes_stream_packer.sv
// Packs WORD_W stream words into BLOCK_W AES blocks behind a valid/ready port.
// Define AES_PACKER_BSWAP_EN to byte-reverse each word before placement.
module aes_stream_packer #(
   parameter int WORD_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int CNT_W   = 16,
   localparam int NW     = BLOCK_W / WORD_W,
   localparam int CW     = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               enable_i,
   input  logic               clear_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WORD_W-1:0]  in_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [BLOCK_W-1:0] out_data_o,
   output logic [CW-1:0]      word_cnt_o,
   output logic [CNT_W-1:0]   blk_cnt_o,
   output logic               busy_o
);

   localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

   logic [BLOCK_W-1:0] fill_q;
   logic [BLOCK_W-1:0] fill_nx;
   logic [BLOCK_W-1:0] out_data_q;
   logic [CW-1:0]      word_cnt_q;
   logic [CNT_W-1:0]   blk_cnt_q;
   logic               out_valid_q;
   logic               flush_pend_q;
   logic [WORD_W-1:0]  word;
   logic               slot_free;
   logic               in_acc;
   logic               out_acc;
   logic               last;
   logic               flush_req;
   logic               flush_go;
   logic               load;

`ifdef AES_PACKER_BSWAP_EN
   always_comb begin
      word = '0;
      for (int b = 0; b < WORD_W / 8; b++) begin
         word[WORD_W-8-8*b +: 8] = in_data_i[8*b +: 8];
      end
   end
`else
   always_comb begin
      word = in_data_i;
   end
`endif

   assign slot_free  = !out_valid_q | out_ready_i;
   assign in_ready_o = enable_i & !flush_pend_q
                     & ((word_cnt_q != LAST_IDX) | slot_free);
   assign in_acc     = in_valid_i & in_ready_o;
   assign out_acc    = enable_i & out_valid_q & out_ready_i;
   assign last       = in_acc & (word_cnt_q == LAST_IDX);

   // A word completing the block wins over a flush in the same cycle.
   assign flush_req  = enable_i & (flush_i | flush_pend_q)
                     & (word_cnt_q != '0);
   assign flush_go   = flush_req & slot_free & !last;
   assign load       = last | flush_go;

   always_comb begin
      fill_nx = fill_q;
      if (in_acc) begin
         fill_nx[WORD_W*word_cnt_q +: WORD_W] = word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         fill_q       <= '0;
         out_data_q   <= '0;
         word_cnt_q   <= '0;
         blk_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         flush_pend_q <= 1'b0;
      end else if (enable_i) begin
         if (load) begin
            out_data_q <= fill_nx;
            fill_q     <= '0;
            word_cnt_q <= '0;
         end else if (in_acc) begin
            fill_q     <= fill_nx;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (load) begin
            out_valid_q <= 1'b1;
         end else if (out_acc) begin
            out_valid_q <= 1'b0;
         end
         if (out_acc) begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
         end
         flush_pend_q <= flush_req & !slot_free & !last;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign word_cnt_o  = word_cnt_q;
   assign blk_cnt_o   = blk_cnt_q;
   assign busy_o      = (word_cnt_q != '0) | out_valid_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Directed bench for aes_stream_packer with a block scoreboard.
// A CNT_W=4 twin shares the stimulus to exercise counter wrap.
module tb_aes_stream_packer;

   logic         clk = 1'b0;
   logic         rst_n, enable, clear, flush, in_valid, out_ready;
   logic [31:0]  in_data;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_data;
   logic [1:0]   word_cnt;
   logic [15:0]  blk_cnt;
   logic         in_ready4, out_valid4, busy4;
   logic [127:0] out_data4;
   logic [1:0]   word_cnt4;
   logic [3:0]   blk_cnt4;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [127:0] exp_q[$];
   logic [127:0] mon_exp;
   logic [127:0] blk_a;
   logic [31:0]  mfill[4];
   int           mcnt = 0;
   int           waits;

   always #5 clk = ~clk;

   aes_stream_packer dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .word_cnt_o(word_cnt), .blk_cnt_o(blk_cnt),
      .busy_o(busy)
   );

   aes_stream_packer #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready4),
      .in_data_i(in_data), .out_valid_o(out_valid4), .out_ready_i(out_ready),
      .out_data_o(out_data4), .word_cnt_o(word_cnt4), .blk_cnt_o(blk_cnt4),
      .busy_o(busy4)
   );

   function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef AES_PACKER_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_push();
      logic [127:0] b;
      b = '0;
      for (int k = 0; k < mcnt; k++) b[32*k +: 32] = mfill[k];
      exp_q.push_back(b);
      mcnt = 0;
   endtask

   task automatic model_word(input logic [31:0] w);
      mfill[mcnt] = bsw(w);
      mcnt++;
      if (mcnt == 4) model_push();
   endtask

   task automatic model_flush();
      if (mcnt > 0) model_push();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, output int nw);
      in_valid = 1'b1;
      in_data  = w;
      nw = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && nw < 40) begin
         nw++;
         @(negedge clk);
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $error("FAIL send_timeout: observed in_ready=%b expected 1", in_ready);
      end else begin
         model_word(w);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("drain_empty", 128'(exp_q.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && clear === 1'b0 && enable === 1'b1 &&
          out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_block: observed %h expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("block", out_data, mon_exp);
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_word_cnt", 128'(word_cnt), 128'd0);
      check("rst_blk_cnt", 128'(blk_cnt), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("dis_in_ready", 128'(in_ready), 128'd0);

      // first block, ordering
      enable = 1'b1;
      out_ready = 1'b1;
      send_word(32'h03020100, waits);
      send_word(32'h07060504, waits);
      send_word(32'h0B0A0908, waits);
      send_word(32'h0F0E0D0C, waits);
      check("t1_out_valid", 128'(out_valid), 128'd1);
`ifdef AES_PACKER_BSWAP_EN
      check("t1_out_data", out_data, 128'h0C0D0E0F_08090A0B_04050607_00010203);
`else
      check("t1_out_data", out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
`endif
      step();
      check("t1_blk_cnt", 128'(blk_cnt), 128'd1);

      // back-to-back streaming
      for (int i = 0; i < 8; i++) begin
         send_word(32'hA0000000 + 32'(i), waits);
         check("b2b_no_stall", 128'(waits), 128'd0);
      end
      drain();
      check("b2b_blk_cnt", 128'(blk_cnt), 128'd3);

      // stall with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) send_word(32'hB0000000 + 32'(i), waits);
      blk_a = exp_q[0];
      check("stall_word_cnt", 128'(word_cnt), 128'd3);
      in_valid = 1'b1;
      in_data  = 32'hB0000007;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 128'(in_ready), 128'd0);
         check("stall_out_data", out_data, blk_a);
      end
      step();
      out_ready = 1'b1;
      #1;
      check("stall_resume", 128'(in_ready), 128'd1);
      model_word(32'hB0000007);
      step();
      in_valid = 1'b0;
      drain();
      check("stall_blk_cnt", 128'(blk_cnt), 128'd5);

      // flush of a partial block
      send_word(32'h11111111, waits);
      send_word(32'h22222222, waits);
      flush = 1'b1;
      model_flush();
      step();
      flush = 1'b0;
      check("flush_word_cnt", 128'(word_cnt), 128'd0);
      check("flush_valid", 128'(out_valid), 128'd1);
      check("flush_data", out_data, 128'h00000000_00000000_22222222_11111111);
      drain();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      check("flush_empty_valid", 128'(out_valid), 128'd0);
      check("flush_empty_blk", 128'(blk_cnt), 128'd6);

      // flush held pending behind a stalled block
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_word(32'hC0000000 + 32'(i), waits);
      flush = 1'b1;
      model_flush();
      step();
      flush = 1'b0;
      check("pend_in_ready", 128'(in_ready), 128'd0);
      check("pend_word_cnt", 128'(word_cnt), 128'd1);
      out_ready = 1'b1;
      drain();
      check("pend_blk_cnt", 128'(blk_cnt), 128'd8);
      check("pend_in_ready_after", 128'(in_ready), 128'd1);

      // enable low freezes a partial fill
      send_word(32'hD0000000, waits);
      enable = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("en_in_ready", 128'(in_ready), 128'd0);
      step();
      step();
      in_valid = 1'b0;
      enable = 1'b1;
      check("en_word_cnt", 128'(word_cnt), 128'd1);

      // clear mid-fill
      send_word(32'hD0000001, waits);
      send_word(32'hD0000002, waits);
      clear = 1'b1;
      step();
      clear = 1'b0;
      mcnt = 0;
      exp_q.delete();
      check("clr_word_cnt", 128'(word_cnt), 128'd0);
      check("clr_blk_cnt", 128'(blk_cnt), 128'd0);
      check("clr_busy", 128'(busy), 128'd0);
      for (int i = 0; i < 4; i++) send_word(32'hE0000000 + 32'(i), waits);
      drain();
      check("clr_new_blk", 128'(blk_cnt), 128'd1);

      // reset mid-fill
      send_word(32'hF0000000, waits);
      send_word(32'hF0000001, waits);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mcnt = 0;
      exp_q.delete();
      check("rst_mid_word_cnt", 128'(word_cnt), 128'd0);
      for (int i = 0; i < 4; i++) send_word(32'h90000000 + 32'(i), waits);
      drain();
      check("rst_mid_blk", 128'(blk_cnt), 128'd1);
      check("rst_mid_blk4", 128'(blk_cnt4), 128'd1);

      // block counter wrap on the 4-bit twin
      for (int i = 0; i < 14 * 4; i++) send_word($urandom, waits);
      drain();
      check("wrap_blk4_15", 128'(blk_cnt4), 128'd15);
      for (int i = 0; i < 4; i++) send_word($urandom, waits);
      drain();
      check("wrap_blk4_0", 128'(blk_cnt4), 128'd0);
      check("wrap_blk16", 128'(blk_cnt), 128'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
